// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package serial_add_pkg;

  // Sequencer states: waiting, shifting bits through the cell, result pulse.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_e;

  // MODE encodings.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder: Y = {carry, sum} of A + B + C, built from gates.
module fa_cell (
  input  logic       A,
  input  logic       B,
  input  logic       C,
  output logic [1:0] Y
);

  logic ab_x_s;
  logic ab_a_s;
  logic cx_a_s;

  assign ab_x_s = A ^ B;
  assign ab_a_s = A & B;
  assign cx_a_s = ab_x_s & C;

  assign Y[0] = ab_x_s ^ C;
  assign Y[1] = ab_a_s | cx_a_s;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit add/subtract sequencer around one shared full-adder cell.
// Operands are shifted LSB first through the cell; the result is published
// to SUM/COUT/OVF only on the final bit and held until the next operation.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         MODE,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] SUM,
  output logic         COUT,
  output logic         OVF
);

  localparam int CW = $clog2(N) + 1;

  state_e         state_q,  state_d;
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic           carry_q,  carry_d;
  logic [N-1:0]   a_sh_q,   a_sh_d;
  logic [N-1:0]   b_sh_q,   b_sh_d;
  logic [N-1:0]   sum_sh_q, sum_sh_d;
  logic [N-1:0]   sum_q,    sum_d;
  logic           cout_q,   cout_d;
  logic           ovf_q,    ovf_d;
  logic           busy_q,   busy_d;
  logic           done_q,   done_d;

  logic [1:0]     cell_y_s;
  logic [N-1:0]   sum_next_s;
  logic           accept_s;

  fa_cell u_fa (
    .A (a_sh_q[0]),
    .B (b_sh_q[0]),
    .C (carry_q),
    .Y (cell_y_s)
  );

  // Result shift register with this step's sum bit entering at the MSB.
  assign sum_next_s = {cell_y_s[0], sum_sh_q[N-1:1]};

  // START is only honoured when not mid-operation.
  assign accept_s = START & ((state_q == IDLE) | (state_q == DONE_S));

  // Next-state, datapath and output-register computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE_S: begin
        if (accept_s) begin
          state_d  = RUN;
          cnt_d    = {CW{1'b0}};
          a_sh_d   = A;
          b_sh_d   = (MODE == MODE_ADD) ? B : ~B;
          carry_d  = (MODE == MODE_SUB) ? 1'b1 : CIN;
          sum_sh_d = {N{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[N-1:1]};
        b_sh_d   = {1'b0, b_sh_q[N-1:1]};
        sum_sh_d = sum_next_s;
        carry_d  = cell_y_s[1];
        if (cnt_q == CW'(N - 1)) begin
          // Last bit: carry_q is the carry into the MSB, cell carry is out of it.
          state_d = DONE_S;
          cnt_d   = cnt_q;
          sum_d   = sum_next_s;
          cout_d  = cell_y_s[1];
          ovf_d   = carry_q ^ cell_y_s[1];
        end else begin
          state_d = RUN;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE_S);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      carry_q  <= 1'b0;
      a_sh_q   <= {N{1'b0}};
      b_sh_q   <= {N{1'b0}};
      sum_sh_q <= {N{1'b0}};
      sum_q    <= {N{1'b0}};
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign SUM  = sum_q;
  assign COUT = cout_q;
  assign OVF  = ovf_q;

endmodule
